// File: rtl/pipe_cla_if.sv
// Operand/result handshake bundle for the pipelined carry-lookahead adder.
// master drives operands and out_ready; slave is the adder.
interface pipe_cla_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             sgn;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ofl;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, sgn, out_ready,
    input  in_ready, out_valid, sum, cout, ofl, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, sgn, out_ready,
    output in_ready, out_valid, sum, cout, ofl, zero
  );
endinterface

// File: rtl/pipe_cla.sv
// Pipelined add/subtract: each stage adds WIDTH/STAGES bits with 4-bit group
// lookahead and hands its carry, partial sum and unused operand bits onward.
module pipe_cla #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic      clk,
  input  logic      rst,
  pipe_cla_if.slave bus
);
  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / 4;

  logic             adv;
  logic [WIDTH-1:0] beff;
  logic             ceff;

  // The whole pipe moves together; it only freezes when a result is waiting.
  assign adv          = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv;
  assign beff         = bus.sub ? ~bus.b : bus.b;
  assign ceff         = bus.sub | bus.cin;

  // Group carries are flattened sum-of-products of the group P/G terms.
  function automatic logic [SW:0] cla_add(input logic [SW-1:0] x,
                                          input logic [SW-1:0] y,
                                          input logic          c0);
    logic [SW-1:0] g, p, s;
    logic [NG-1:0] gg, gp;
    logic [NG:0]   gc;
    logic [3:0]    pj, gj, bc;
    logic          t, term;
    g = x & y;
    p = x ^ y;
    s = '0;
    for (int j = 0; j < NG; j++) begin
      pj    = p[4*j +: 4];
      gj    = g[4*j +: 4];
      gp[j] = &pj;
      gg[j] = gj[3] | (pj[3] & gj[2]) | (pj[3] & pj[2] & gj[1])
            | (pj[3] & pj[2] & pj[1] & gj[0]);
    end
    gc[0] = c0;
    for (int j = 1; j <= NG; j++) begin
      t = c0;
      for (int i = 0; i < j; i++) t = t & gp[i];
      for (int i = 0; i < j; i++) begin
        term = gg[i];
        for (int m = i + 1; m < j; m++) term = term & gp[m];
        t = t | term;
      end
      gc[j] = t;
    end
    for (int j = 0; j < NG; j++) begin
      pj    = p[4*j +: 4];
      gj    = g[4*j +: 4];
      bc[0] = gc[j];
      bc[1] = gj[0] | (pj[0] & gc[j]);
      bc[2] = gj[1] | (pj[1] & gj[0]) | (pj[1] & pj[0] & gc[j]);
      bc[3] = gj[2] | (pj[2] & gj[1]) | (pj[2] & pj[1] & gj[0])
            | (pj[2] & pj[1] & pj[0] & gc[j]);
      s[4*j +: 4] = pj ^ bc;
    end
    return {gc[NG], s};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO = k * SW;
    localparam int RW = WIDTH - LO;
    localparam int HI = LO + SW;

    logic [RW-1:0] src_a, src_b;
    logic          src_v, src_c, src_sub, src_sgn;
    logic [SW:0]   res;
    logic [HI-1:0] nsum;
    logic          v_q, c_q;
    logic [HI-1:0] sum_q;

    if (k == 0) begin : g_src
      assign src_a   = bus.a;
      assign src_b   = beff;
      assign src_c   = ceff;
      assign src_v   = bus.in_valid;
      assign src_sub = bus.sub;
      assign src_sgn = bus.sgn;
      assign nsum    = res[SW-1:0];
    end else begin : g_src
      assign src_a   = stg[k-1].g_rem.a_q;
      assign src_b   = stg[k-1].g_rem.b_q;
      assign src_c   = stg[k-1].c_q;
      assign src_v   = stg[k-1].v_q;
      assign src_sub = stg[k-1].g_rem.sub_q;
      assign src_sgn = stg[k-1].g_rem.sgn_q;
      assign nsum    = {res[SW-1:0], stg[k-1].sum_q};
    end

    assign res = cla_add(src_a[SW-1:0], src_b[SW-1:0], src_c);

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        v_q   <= src_v;
        c_q   <= res[SW];
        sum_q <= nsum;
      end
    end

    if (k < STAGES - 1) begin : g_rem
      logic [RW-SW-1:0] a_q, b_q;
      logic             sub_q, sgn_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q   <= '0;
          b_q   <= '0;
          sub_q <= 1'b0;
          sgn_q <= 1'b0;
        end else if (adv) begin
          a_q   <= src_a[RW-1:SW];
          b_q   <= src_b[RW-1:SW];
          sub_q <= src_sub;
          sgn_q <= src_sgn;
        end
      end
    end else begin : g_last
      logic ofl_n, zero_n, ofl_q, zero_q;
      // Unsigned subtract reports borrow, i.e. the inverted carry.
      assign ofl_n  = src_sgn ? ((src_a[RW-1] == src_b[RW-1]) & (res[SW-1] != src_a[RW-1]))
                              : (src_sub ? ~res[SW] : res[SW]);
      assign zero_n = ~|nsum;
      always_ff @(posedge clk) begin
        if (rst) begin
          ofl_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ofl_q  <= ofl_n;
          zero_q <= zero_n;
        end
      end
    end
  end

  assign bus.out_valid = stg[STAGES-1].v_q;
  assign bus.sum       = stg[STAGES-1].sum_q;
  assign bus.cout      = stg[STAGES-1].c_q;
  assign bus.ofl       = stg[STAGES-1].g_last.ofl_q;
  assign bus.zero      = stg[STAGES-1].g_last.zero_q;
endmodule

// File: tb/tb_pipe_cla.sv
// Bench for pipe_cla: directed vector table, stall and reset sequences,
// then random traffic scored against an arithmetic reference model.
module tb_pipe_cla;
  localparam int WIDTH  = 32;
  localparam int STAGES = 2;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_cla_if #(.WIDTH(WIDTH)) bus ();
  pipe_cla #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ofl;
    logic        zero;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        sgn;
    logic [31:0] sum;
    logic        cout;
    logic        ofl;
    logic        zero;
  } vec_t;

  res_t exp_q[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   n_recv = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub, input logic sgn);
    res_t        r;
    logic [32:0] full;
    logic [31:0] be;
    longint      s;
    longint      u;
    be     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, be} + 33'(sub ? 1'b1 : cin);
    r.sum  = full[31:0];
    r.cout = full[32];
    r.zero = (r.sum == 32'd0);
    if (sgn) begin
      s = sub ? longint'($signed(a)) - longint'($signed(b))
              : longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
      r.ofl = (s > SMAX) || (s < SMIN);
    end else if (sub) begin
      r.ofl = (a < b);
    end else begin
      u = longint'({32'd0, a}) + longint'({32'd0, b}) + longint'(cin);
      r.ofl = (u > 64'sh0000_0000_FFFF_FFFF);
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard and hold monitor; all DUT sampling on the falling edge.
  initial begin
    logic hold_v;
    res_t held;
    res_t e;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("hold_valid", 64'(bus.out_valid), 64'(1));
          check("hold_sum", 64'(bus.sum), 64'(held.sum));
          check("hold_flags", 64'({bus.cout, bus.ofl, bus.zero}),
                64'({held.cout, held.ofl, held.zero}));
        end
        hold_v = bus.out_valid && !bus.out_ready;
        if (hold_v) begin
          held.sum  = bus.sum;
          held.cout = bus.cout;
          held.ofl  = bus.ofl;
          held.zero = bus.zero;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL spurious_result: got sum %0h want no result", bus.sum);
          end else begin
            e = exp_q.pop_front();
            check("res_sum", 64'(bus.sum), 64'(e.sum));
            check("res_flags", 64'({bus.cout, bus.ofl, bus.zero}), 64'({e.cout, e.ofl, e.zero}));
            n_recv++;
          end
        end
        if (bus.in_valid && bus.in_ready)
          exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub, bus.sgn));
      end
    end
  end

  task automatic drive_op(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input logic sgn);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
    bus.sgn      = sgn;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_random();
    logic ok;
    ok = 1'b0;
    drive_op(rand_op(), rand_op(), 1'($urandom), 1'($urandom), 1'($urandom));
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) timeout("send_accept");
    bus.in_valid = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    int lat;
    bit got;
    int base;

    vecs[0] = '{32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0005, 32'h7,         1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0005, 32'h7,         1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_FFFF, 32'h1,         1'b0, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_0000, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{32'h8000_0000, 32'h1,         1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.sgn       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_in_ready", 64'(bus.in_ready), 64'(1));
    check("reset_sum", 64'(bus.sum), 64'(0));
    check("reset_flags", 64'({bus.cout, bus.ofl, bus.zero}), 64'(0));

    // Directed vectors, one at a time, measuring latency.
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].sgn);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      lat = 1;
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        @(negedge clk);
        if (bus.out_valid) got = 1'b1;
        else begin
          @(posedge clk);
          lat++;
        end
      end
      if (!got) timeout("vec_out_valid");
      else begin
        check($sformatf("vec%0d_latency", i), 64'(lat), 64'(STAGES));
        check($sformatf("vec%0d_sum", i), 64'(bus.sum), 64'(vecs[i].sum));
        check($sformatf("vec%0d_flags", i), 64'({bus.cout, bus.ofl, bus.zero}),
              64'({vecs[i].cout, vecs[i].ofl, vecs[i].zero}));
      end
      @(posedge clk);
      #1;
    end

    // Four back-to-back ops against a three-cycle output stall.
    base = n_recv;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_random();
      end
      begin
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
          @(negedge clk);
          got = bus.out_valid;
        end
        if (!got) timeout("stall_out_valid");
        for (int s = 0; s < 3; s++) begin
          check("stall_in_ready", 64'(bus.in_ready), 64'(0));
          check("stall_out_valid", 64'(bus.out_valid), 64'(1));
          @(posedge clk);
          #1;
          if (s < 2) @(negedge clk);
        end
        bus.out_ready = 1'b1;
      end
    join
    for (int c = 0; c < 20 && (n_recv - base) < 4; c++) @(posedge clk);
    #1;
    check("stall_count", 64'(n_recv - base), 64'(4));

    // Reset with two ops in flight; an op offered during reset must be ignored.
    bus.out_ready = 1'b0;
    send_random();
    send_random();
    rst = 1'b1;
    drive_op(32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_sum", 64'(bus.sum), 64'(0));
    check("rst_flags", 64'({bus.cout, bus.ofl, bus.zero}), 64'(0));
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rst_no_result", 64'(bus.out_valid), 64'(0));
    end

    // Random traffic with random backpressure.
    @(posedge clk);
    #1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) < 7)
        drive_op(rand_op(), rand_op(), 1'($urandom), 1'($urandom), 1'($urandom));
      else
        bus.in_valid = 1'b0;
      bus.out_ready = ($urandom_range(0, 9) < 6);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    check("drain_out_valid", 64'(bus.out_valid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_cla.md
PIPE_CLA -- requirements
Module: pipe_cla

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand and result width, a multiple of 4 and of STAGES.
REQ-002 The block SHALL have parameter STAGES, default 2, the pipeline depth, 1..WIDTH/4, dividing WIDTH/4.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid  input  1  an operand set is present on a, b, cin, sub, sgn.
REQ-006 The block SHALL have port in_ready  output  1  the block accepts an operand set this cycle.
REQ-007 The block SHALL have port a  input  WIDTH  operand A.
REQ-008 The block SHALL have port b  input  WIDTH  operand B.
REQ-009 The block SHALL have port cin  input  1  carry in, add mode only.
REQ-010 The block SHALL have port sub  input  1  1 = A minus B.
REQ-011 The block SHALL have port sgn  input  1  1 = signed overflow rule, 0 = unsigned.
REQ-012 The block SHALL have port out_valid  output  1  a result is present on sum, cout, ofl, zero.
REQ-013 The block SHALL have port out_ready  input  1  downstream takes the result this cycle.
REQ-014 The block SHALL have port sum  output  WIDTH  result.
REQ-015 The block SHALL have ports cout  output  1  carry out of the MSB; ofl  output  1  overflow; zero  output  1  sum == 0.

Function
REQ-016 The effective operand SHALL be Beff = sub ? ~b : b, and the effective carry in Ceff = sub ? 1 : cin; in subtract mode cin SHALL be ignored.
REQ-017 {cout, sum} SHALL equal a + Beff + Ceff modulo 2^(WIDTH+1).
REQ-018 Stage k (0..STAGES-1) SHALL compute sum bits [(k+1)*W/STAGES-1 : k*W/STAGES], W = WIDTH, from the carry registered by stage k-1 (stage 0 uses Ceff).
REQ-019 Within a stage, addition SHALL use 4-bit group propagate/generate with lookahead across groups; no ripple between 4-bit groups.
REQ-020 Each stage register SHALL hold a valid bit, the partial sum, the stage carry, and the not-yet-consumed a, Beff, sub and sgn bits.
REQ-021 Latency SHALL be exactly STAGES cycles from an accepting edge (in_valid & in_ready) to out_valid with no stall; throughput SHALL be one result per cycle.
REQ-022 Advance SHALL be adv = out_ready | ~out_valid; all stage registers SHALL load only when adv = 1, and in_ready SHALL equal adv.
REQ-023 When adv = 1 and in_valid = 0, a bubble (valid bit 0) SHALL enter stage 0.
REQ-024 While out_valid = 1 and out_ready = 0, sum, cout, ofl, zero and out_valid SHALL hold constant.
REQ-025 ofl SHALL be, when sgn = 1: (a[W-1] == Beff[W-1]) & (sum[W-1] != a[W-1]); when sgn = 0 and sub = 0: cout; when sgn = 0 and sub = 1: ~cout (borrow).
REQ-026 zero SHALL be 1 exactly when all WIDTH sum bits are 0, independent of cout.
REQ-027 Operand sets SHALL emerge in acceptance order; none SHALL be dropped or duplicated under any out_ready pattern.
REQ-028 With STAGES = 1, the block SHALL register the full result once, giving latency 1.

Reset
REQ-029 When rst = 1 at a rising edge, every stage valid bit SHALL clear, and out_valid, sum, cout, ofl, zero SHALL be 0 on the next cycle.
REQ-030 Operations in flight at reset SHALL be discarded, with no result appearing afterwards.
REQ-031 in_ready SHALL be 1 in the first cycle after reset, since out_valid is 0.
REQ-032 Operands presented in a cycle with rst = 1 SHALL NOT be accepted.

Verification (WIDTH=32, STAGES=2)
REQ-033 The bench SHALL cover: a=0xFFFFFFFF, b=1, cin=0, sub=0, sgn=0 -> after 2 cycles sum=0, cout=1, ofl=1, zero=1.
REQ-034 The bench SHALL cover: a=0x7FFFFFFF, b=1, sgn=1, sub=0 -> sum=0x80000000, cout=0, ofl=1, zero=0.
REQ-035 The bench SHALL cover: a=5, b=7, sub=1, sgn=0 -> sum=0xFFFFFFFE, cout=0, ofl=1 (borrow); with sgn=1 -> ofl=0.
REQ-036 The bench SHALL cover: 4 back-to-back ops, out_ready held 0 for 3 cycles then 1 -> in_ready low during the stall, output held, all 4 results in order, no loss.
REQ-037 The bench SHALL cover: rst=1 with 2 ops in flight -> out_valid=0 next cycle, and neither result ever appears.
REQ-038 The bench SHALL cover: a=0x0000FFFF, b=1, cin=0 -> carry crosses the stage boundary, sum=0x00010000, cout=0.
